// File: rtl/cpu_pkg.sv
// Shared Mini SRC definitions: opcodes, IR field positions, control-unit states and decode helpers.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_cls_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_RA, SEL_RB, SEL_RC} reg_sel_e;

  function automatic instr_cls_e classify(input logic [4:0] op);
    instr_cls_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:     cls = CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:            cls = CLS_IMM;
      OP_NEG, OP_NOT:                      cls = CLS_UNARY;
      OP_MUL, OP_DIV:                      cls = CLS_MULDIV;
      OP_NOP:                              cls = CLS_NOP;
      OP_HALT:                             cls = CLS_HALT;
      default:                             cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR and memory-ready in, every datapath strobe out.
interface control_unit_if;
  import cpu_pkg::*;

  // mem_rdy acts as the valid of a read: the control unit holds Read in T1 and
  // completes the fetch on the first rising edge that sees mem_rdy high.
  logic [31:0] IR;
  logic        mem_rdy;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, ZLOin, ZLOout, ZHIout, HIin, Loin, Cout;
  logic [4:0]  ALU_opcode;
  logic        Run, illegal, mem_timeout;
  state_e      state_dbg;

  modport master (
    input  IR, mem_rdy,
    output R_in, R_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
           Yin, Zin, ZLOin, ZLOout, ZHIout, HIin, Loin, Cout,
           ALU_opcode, Run, illegal, mem_timeout, state_dbg
  );

  modport slave (
    output IR, mem_rdy,
    input  R_in, R_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
           Yin, Zin, ZLOin, ZLOout, ZHIout, HIin, Loin, Cout,
           ALU_opcode, Run, illegal, mem_timeout, state_dbg
  );

endinterface

// File: rtl/select_encode.sv
// Turns the IR register fields plus read/write field selects into one-hot R_out/R_in enables.
module select_encode
  import cpu_pkg::*;
(
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic [3:0]  rc_i,
  input  reg_sel_e    rd_sel_i,
  input  reg_sel_e    wr_sel_i,
  output logic [15:0] r_in_o,
  output logic [15:0] r_out_o
);

  function automatic logic [15:0] one_hot(input reg_sel_e sel, input logic [3:0] fa,
                                          input logic [3:0] fb, input logic [3:0] fc);
    logic [15:0] vec;
    vec = '0;
    case (sel)
      SEL_RA:  vec[fa] = 1'b1;
      SEL_RB:  vec[fb] = 1'b1;
      SEL_RC:  vec[fc] = 1'b1;
      default: vec = '0;
    endcase
    return vec;
  endfunction

  assign r_in_o  = one_hot(wr_sel_i, ra_i, rb_i, rc_i);
  assign r_out_o = one_hot(rd_sel_i, ra_i, rb_i, rc_i);

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control unit: fetch/execute FSM driving the datapath strobes.
// Optional feature: define MULDIV_EN to enable the mul/div sequences.
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic clk,
  input logic clr,
  control_unit_if.master bus
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 2);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MEM_WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [4:0]    op;
  instr_cls_e    cls;
  reg_sel_e      rd_sel, wr_sel;
  logic          unused_ir;

  assign op        = bus.IR[OP_MSB:OP_LSB];
  assign unused_ir = ^bus.IR[RC_LSB-1:0];

`ifdef MULDIV_EN
  assign cls = classify(op);
`else
  assign cls = (classify(op) == CLS_MULDIV) ? CLS_ILLEGAL : classify(op);
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    rd_sel  = SEL_NONE;
    wr_sel  = SEL_NONE;
    bus.PCout = 1'b0;  bus.PCin   = 1'b0;  bus.IncPC  = 1'b0;  bus.MARin = 1'b0;
    bus.MDRin = 1'b0;  bus.MDRout = 1'b0;  bus.Read   = 1'b0;  bus.IRin  = 1'b0;
    bus.Yin   = 1'b0;  bus.Zin    = 1'b0;  bus.ZLOin  = 1'b0;  bus.ZLOout = 1'b0;
    bus.ZHIout = 1'b0; bus.HIin   = 1'b0;  bus.Loin   = 1'b0;  bus.Cout  = 1'b0;
    bus.ALU_opcode  = '0;
    bus.illegal     = 1'b0;
    bus.mem_timeout = 1'b0;
    bus.Run = (state_q != ST_RESET) && (state_q != ST_HALT);
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; bus.ZLOin = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        // wait_q is zero only on the first T1 cycle, so PC is loaded exactly once.
        bus.ZLOout = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        bus.PCin        = (wait_q == '0);
        bus.mem_timeout = (wait_q == WAIT_MAX);
        if (bus.mem_rdy) begin
          state_d = ST_T2;
        end else begin
          wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WW'(1);
        end
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (cls)
          CLS_ALU3, CLS_IMM: begin rd_sel = SEL_RB; bus.Yin = 1'b1; end
          CLS_UNARY: begin
            rd_sel = SEL_RB; bus.ALU_opcode = op; bus.Zin = 1'b1; bus.ZLOin = 1'b1;
          end
          CLS_MULDIV: begin rd_sel = SEL_RA; bus.Yin = 1'b1; end
          CLS_NOP:    state_d = ST_T0;
          CLS_HALT:   state_d = ST_HALT;
          default: begin bus.illegal = 1'b1; state_d = ST_T0; end
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls)
          CLS_ALU3: begin
            rd_sel = SEL_RC; bus.ALU_opcode = op; bus.Zin = 1'b1; bus.ZLOin = 1'b1;
          end
          CLS_IMM: begin
            bus.Cout = 1'b1; bus.ALU_opcode = op; bus.Zin = 1'b1; bus.ZLOin = 1'b1;
          end
          CLS_UNARY:  begin bus.ZLOout = 1'b1; wr_sel = SEL_RA; state_d = ST_T0; end
          CLS_MULDIV: begin rd_sel = SEL_RB; bus.ALU_opcode = op; bus.Zin = 1'b1; end
          default:    state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T0;
        case (cls)
          CLS_ALU3, CLS_IMM: begin bus.ZLOout = 1'b1; wr_sel = SEL_RA; end
          CLS_MULDIV: begin bus.ZLOout = 1'b1; bus.Loin = 1'b1; state_d = ST_T6; end
          default:    state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        bus.ZHIout = 1'b1; bus.HIin = 1'b1;
        state_d = ST_T0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
`ifndef MULDIV_EN
    bus.HIin   = 1'b0;
    bus.Loin   = 1'b0;
    bus.ZHIout = 1'b0;
`endif
  end

  assign bus.state_dbg = state_q;

  select_encode u_select_encode (
    .ra_i     (bus.IR[RA_MSB:RA_LSB]),
    .rb_i     (bus.IR[RB_MSB:RB_LSB]),
    .rc_i     (bus.IR[RC_MSB:RC_LSB]),
    .rd_sel_i (rd_sel),
    .wr_sel_i (wr_sel),
    .r_in_o   (bus.R_in),
    .r_out_o  (bus.R_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction step tables feed an expected queue compared every cycle.
// Honours MULDIV_EN the same way the design does.
module tb_control_unit;

  localparam int W            = 56;
  localparam int MEM_WAIT_MAX = 15;
  localparam int POS_PCIN     = 9;
  localparam int POS_TMO      = 0;

  localparam logic [15:0] B_PCOUT  = 16'h0001, B_PCIN   = 16'h0002, B_INCPC  = 16'h0004;
  localparam logic [15:0] B_MARIN  = 16'h0008, B_MDRIN  = 16'h0010, B_MDROUT = 16'h0020;
  localparam logic [15:0] B_READ   = 16'h0040, B_IRIN   = 16'h0080, B_YIN    = 16'h0100;
  localparam logic [15:0] B_ZIN    = 16'h0200, B_ZLOIN  = 16'h0400, B_ZLOOUT = 16'h0800;
  localparam logic [15:0] B_ZHIOUT = 16'h1000, B_HIIN   = 16'h2000, B_LOIN   = 16'h4000;
  localparam logic [15:0] B_COUT   = 16'h8000;

`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] act;

  control_unit_if bus();

  control_unit #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.R_in, bus.R_out,
                bus.Cout, bus.Loin, bus.HIin, bus.ZHIout, bus.ZLOout, bus.ZLOin, bus.Zin, bus.Yin,
                bus.IRin, bus.Read, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout,
                bus.ALU_opcode, bus.Run, bus.illegal, bus.mem_timeout};

  // ---------------- model ----------------
  function automatic logic [W-1:0] mk(input logic [15:0] st, input logic [15:0] rin,
                                      input logic [15:0] rout, input logic [4:0] alu,
                                      input logic ill, input logic tmo);
    return {rin, rout, st, alu, 1'b1, ill, tmo};
  endfunction

  function automatic logic [31:0] f_rin(input logic [W-1:0] v);  return {16'h0, v[55:40]}; endfunction
  function automatic logic [31:0] f_rout(input logic [W-1:0] v); return {16'h0, v[39:24]}; endfunction
  function automatic logic [31:0] f_st(input logic [W-1:0] v);   return {16'h0, v[23:8]};  endfunction
  function automatic logic [31:0] f_alu(input logic [W-1:0] v);  return {27'h0, v[7:3]};   endfunction
  function automatic logic [31:0] f_ill(input logic [W-1:0] v);  return {31'h0, v[1]};     endfunction

  function automatic int count_bit(input int pos);
    int n = 0;
    foreach (seq_q[i]) if (seq_q[i][pos]) n++;
    return n;
  endfunction

  task automatic build_seq(input logic [31:0] ir, input int waits);
    logic [4:0]  opc;
    int          op;
    logic [15:0] oa, ob, oc;
    opc = ir[31:27];
    op  = int'(opc);
    oa  = 16'h1 << ir[26:23];
    ob  = 16'h1 << ir[22:19];
    oc  = 16'h1 << ir[18:15];
    seq_q.delete();
    seq_q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_ZLOIN, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    for (int w = 0; w <= waits; w++)
      seq_q.push_back(mk(B_ZLOOUT | B_READ | B_MDRIN | ((w == 0) ? B_PCIN : 16'h0),
                         16'h0, 16'h0, 5'd0, 1'b0, (w == MEM_WAIT_MAX)));
    seq_q.push_back(mk(B_MDROUT | B_IRIN, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    if (op >= 3 && op <= 14) begin
      seq_q.push_back(mk(B_YIN, 16'h0, ob, 5'd0, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZIN | B_ZLOIN | ((op >= 12) ? B_COUT : 16'h0), 16'h0,
                         (op >= 12) ? 16'h0 : oc, opc, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZLOOUT, oa, 16'h0, 5'd0, 1'b0, 1'b0));
    end else if (op == 17 || op == 18) begin
      seq_q.push_back(mk(B_ZIN | B_ZLOIN, 16'h0, ob, opc, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZLOOUT, oa, 16'h0, 5'd0, 1'b0, 1'b0));
    end else if (MD_EN && (op == 15 || op == 16)) begin
      seq_q.push_back(mk(B_YIN, 16'h0, oa, 5'd0, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZIN, 16'h0, ob, opc, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZLOOUT | B_LOIN, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
      seq_q.push_back(mk(B_ZHIOUT | B_HIIN, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    end else if (op == 26 || op == 27) begin
      seq_q.push_back(mk(16'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    end else begin
      seq_q.push_back(mk(16'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0));
    end
  endtask

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL cycle %0d: no expected outputs queued (state=%s)", cyc, bus.state_dbg.name());
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          failures++;
          $display("FAIL cycle %0d outputs (state=%s): got %h expected %h",
                   cyc, bus.state_dbg.name(), act, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input int cycles);
    for (int i = 0; i <= cycles; i++) exp_q.push_back('0);
    clr = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) exp_q.push_back('0);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at);
    int n;
    build_seq(ir, waits);
    n = seq_q.size();
    if (abort_at > 0 && abort_at < n) n = abort_at;
    for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    for (int c = 0; c < n; c++) begin
      bus.mem_rdy = (c >= 1 + waits);
      if (c == 3 + waits) bus.IR = ir;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.IR      = '0;
    bus.mem_rdy = 1'b0;
    clr         = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset(2);

    run_instr(32'h19890000, 0, 0);                 // add R3,R1,R2
    check("add_len", seq_q.size(), 6);
    check("add_t3_rout", f_rout(seq_q[3]), 32'h0002);
    check("add_t4_rout", f_rout(seq_q[4]), 32'h0004);
    check("add_t4_alu", f_alu(seq_q[4]), 32'h03);
    check("add_t5_rin", f_rin(seq_q[5]), 32'h0008);

    run_instr(32'h19908000, 2, 0);                 // add R3,R2,R1 with two wait cycles
    run_instr(32'h90080000, 0, 0);                 // not R0,R1
    check("not_len", seq_q.size(), 5);
    check("not_t3_rout", f_rout(seq_q[3]), 32'h0002);
    check("not_t3_alu", f_alu(seq_q[3]), 32'h12);
    check("not_t4_rin", f_rin(seq_q[4]), 32'h0001);

    run_instr(32'h61380000, 1, 0);                 // addi R2,R7
    check("addi_t4_cout", f_st(seq_q[5]), 32'(B_ZIN | B_ZLOIN | B_COUT));
    run_instr(32'h5AAA8000, 0, 0);                 // shl R5,R5,R5
    run_instr(32'h8CF80000, 0, 0);                 // neg R9,R15

    run_instr(32'h19890000, 20, 0);                // twenty-cycle memory stall
    check("wait_len", seq_q.size(), 26);
    check("wait_pcin_count", count_bit(POS_PCIN), 1);
    check("wait_timeout_count", count_bit(POS_TMO), 1);
    check("wait_timeout_pos", {31'h0, seq_q[16][POS_TMO]}, 32'h1);

    run_instr(32'h82280000, 0, 0);                 // mul R4,R5
`ifdef MULDIV_EN
    check("mul_len", seq_q.size(), 7);
    check("mul_t3_rout", f_rout(seq_q[3]), 32'h0010);
    check("mul_t4_rout", f_rout(seq_q[4]), 32'h0020);
    check("mul_t5_strobes", f_st(seq_q[5]), 32'(B_ZLOOUT | B_LOIN));
    check("mul_t6_strobes", f_st(seq_q[6]), 32'(B_ZHIOUT | B_HIIN));
`else
    check("mul_len", seq_q.size(), 4);
    check("mul_t3_illegal", f_ill(seq_q[3]), 32'h1);
`endif
    run_instr(32'h7B380000, 0, 0);                 // div R6,R7

    run_instr(32'hD0000000, 0, 0);                 // nop
    check("nop_len", seq_q.size(), 4);
    run_instr(32'h00000000, 0, 0);                 // op 0 is unsupported
    check("ill0_t3", f_ill(seq_q[3]), 32'h1);
    run_instr(32'hF8000000, 3, 0);                 // op 31 is unsupported

    run_instr(32'h19890000, 0, 4);                 // abandoned in T4 by clr
    do_reset(1);

    run_instr(32'hD8000000, 0, 0);                 // halt
    check("halt_len", seq_q.size(), 4);
    idle(10);
    do_reset(1);
    run_instr(32'h90080000, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
